// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add per clock, LSB first.
// Result and carry are published on the completion edge only.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] op_a, op_a_n;
    logic [WIDTH-1:0] op_b, op_b_n;
    logic [WIDTH-1:0] res, res_n;
    logic [WIDTH-1:0] sum_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             carry, carry_n;
    logic             c_out_n;
    logic             busy_n;
    logic             done_n;

    logic             ha1_s, ha1_c;
    logic             ha2_s, ha2_c;
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] res_shift;
    logic             last_bit;

    // Full add of the operand LSBs and the carry, built from two half adders.
    always_comb begin
        ha1_s     = op_a[0] ^ op_b[0];
        ha1_c     = op_a[0] & op_b[0];
        ha2_s     = ha1_s ^ carry;
        ha2_c     = ha1_s & carry;
        fa_s      = ha2_s;
        fa_c      = ha1_c | ha2_c;
        res_shift = {fa_s, res[WIDTH-1:1]};
        last_bit  = (cnt == CW'(WIDTH - 1));
    end

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        state_n = state;
        op_a_n  = op_a;
        op_b_n  = op_b;
        res_n   = res;
        cnt_n   = cnt;
        carry_n = carry;
        sum_n   = sum;
        c_out_n = c_out;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = ADD;
                    op_a_n  = a;
                    op_b_n  = b;
                    res_n   = '0;
                    cnt_n   = '0;
                    carry_n = 1'b0;
                end
            end
            ADD: begin
                op_a_n  = op_a >> 1;
                op_b_n  = op_b >> 1;
                res_n   = res_shift;
                carry_n = fa_c;
                cnt_n   = cnt + CW'(1);
                if (last_bit) begin
                    sum_n   = res_shift;
                    c_out_n = fa_c;
                    done_n  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State, datapath and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            op_a  <= op_a_n;
            op_b  <= op_b_n;
            res   <= res_n;
            cnt   <= cnt_n;
            carry <= carry_n;
            sum   <= sum_n;
            c_out <= c_out_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH 8 and 16.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, c8;
    logic [7:0]  sum8;
    logic        start16;
    logic [15:0] a16, b16;
    logic        busy16, done16, c16;
    logic [15:0] sum16;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(c8)
    );

    serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .c_out(c16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb,
                        input logic [7:0] es, input logic ec,
                        input string nm);
        logic [7:0] s0;
        int lat;
        int chg;
        chg = 0;
        @(negedge clk);
        a8 = ta; b8 = tb; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        chk({nm, " busy"}, busy8, 1);
        s0 = sum8;
        lat = 0;
        while (!done8 && lat < 40) begin
            if (sum8 !== s0) chg++;
            @(negedge clk);
            lat++;
        end
        chk({nm, " lat"}, lat, 8);
        chk({nm, " sum"}, sum8, es);
        chk({nm, " cout"}, c8, ec);
        chk({nm, " hold"}, chg, 0);
        @(negedge clk);
        chk({nm, " pulse"}, {busy8, done8}, 2'b00);
    endtask

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb);
        logic [16:0] exp;
        int lat;
        exp = {1'b0, ta} + {1'b0, tb};
        @(negedge clk);
        a16 = ta; b16 = tb; start16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("w16 lat", lat, 16);
        chk("w16 result", {c16, sum16}, exp);
        @(negedge clk);
        chk("w16 busy fall", busy16, 0);
    endtask

    vec_t vt[9];

    initial begin
        int dn, bl, last, gap_err, dbl, sum_err;
        logic prev_busy;
        logic [8:0] e9;

        vt[0] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vt[1] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
        vt[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vt[3] = '{8'h03, 8'h04, 8'h07, 1'b0};
        vt[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vt[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vt[6] = '{8'h7F, 8'h01, 8'h80, 1'b0};
        vt[7] = '{8'h12, 8'h34, 8'h46, 1'b0};
        vt[8] = '{8'hC8, 8'h64, 8'h2C, 1'b1};

        start8 = 0; a8 = 0; b8 = 0;
        start16 = 0; a16 = 0; b16 = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset outs8", {busy8, done8, c8, sum8}, 0);
        chk("reset outs16", {busy16, done16, c16, sum16}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run8(vt[i].a, vt[i].b, vt[i].s, vt[i].c, $sformatf("vec%0d", i));

        // Request during an operation is ignored.
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h04; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done8) dn++;
        end
        chk("iso pulses", dn, 1);
        chk("iso sum", sum8, 8'h07);
        chk("iso cout", c8, 0);
        chk("iso idle", busy8, 0);

        // Start held high: one result every 10 cycles.
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        dn = 0; bl = 0; last = -1; gap_err = 0; dbl = 0; sum_err = 0;
        prev_busy = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done8) begin
                if (last >= 0 && k - last != 10) gap_err++;
                last = k;
                dn++;
            end
            if (!busy8) begin
                bl++;
                if (!prev_busy) dbl++;
            end
            prev_busy = busy8;
            if (dn > 0 && sum8 !== 8'h33) sum_err++;
        end
        start8 = 1'b0;
        chk("b2b pulses", dn, 3);
        chk("b2b gaps", gap_err, 0);
        chk("b2b idle cycles", bl, 3);
        chk("b2b idle run", dbl, 0);
        chk("b2b sum hold", sum_err, 0);
        repeat (12) @(negedge clk);

        // Reset in the middle of an addition.
        run8(8'hFF, 8'h01, 8'h00, 1'b1, "pre-rst");
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst", {busy8, done8, c8, sum8}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done8) dn++;
        end
        chk("rst no done", dn, 0);
        chk("rst sum", {c8, sum8}, 0);
        run8(8'h10, 8'h20, 8'h30, 1'b0, "post-rst");

        // Random regression at both widths.
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            e9 = {1'b0, ra} + {1'b0, rb};
            run8(ra, rb, e9[7:0], e9[8], "rnd8");
        end
        for (int i = 0; i < 1000; i++)
            run16(16'($urandom), 16'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: start  input  1  request to add a and b; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  addend; captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  addend; captured on the accepting edge.
REQ-007 Port: busy  output  1  high whenever state is not IDLE.
REQ-008 Port: done  output  1  one-cycle completion pulse.
REQ-009 Port: sum  output  WIDTH  result of the last completed addition, a+b modulo 2^WIDTH.
REQ-010 Port: c_out  output  1  carry out of bit WIDTH-1 of the last completed addition.

Function
REQ-011 The block SHALL implement the FSM states IDLE, ADD and DONE, with all outputs driven from registers.
REQ-012 IDLE: start=1 at an edge SHALL load a and b into internal shift registers, clear the carry flip-flop, clear the bit counter, and move to ADD.
REQ-013 IDLE: start=0 SHALL leave all state unchanged.
REQ-014 ADD: each edge SHALL add bit 0 of each operand and the carry flip-flop as a full add built from two half-add stages.
REQ-015 ADD: each edge SHALL shift the sum bit into the MSB of the internal result register, shift both operand registers right by one, update the carry flip-flop, and increment the counter.
REQ-016 ADD: the edge that processes bit WIDTH-1 SHALL copy the completed result to sum, copy the final carry to c_out, and move to DONE.
REQ-017 DONE: done SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE unconditionally.
REQ-018 Latency: with start accepted at edge E0, bits SHALL be processed at edges E1..E_WIDTH, done SHALL be high in the cycle after E_WIDTH, and busy SHALL fall after E_WIDTH+1.
REQ-019 Operand isolation: start, a and b SHALL be ignored while busy=1; no queuing and no abort.
REQ-020 Back-to-back: start held high SHALL begin the next operation on the first IDLE edge, giving a throughput of one result per WIDTH+2 cycles.
REQ-021 Output stability: sum and c_out SHALL change only on the completion edge and SHALL hold their value through DONE, IDLE and the following operation until that operation completes.
REQ-022 Overflow: the carry beyond bit WIDTH-1 SHALL appear only on c_out; sum SHALL wrap modulo 2^WIDTH.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, busy=0, done=0, sum=0, c_out=0, and clear the counter, the carry flip-flop and the shift registers.
REQ-024 Reset asserted mid-operation SHALL discard the operation: no done pulse, and sum/c_out read 0.
REQ-025 After rst_n returns high, the first rising edge SHALL be able to accept start.

Verification
REQ-026 WIDTH=8, a=8'hFF, b=8'h01, start pulse -> done exactly 8 cycles after the accepting edge, sum=8'h00, c_out=1.
REQ-027 a=8'hA5, b=8'h5A -> sum=8'hFF, c_out=0; a=0, b=0 -> sum=0, c_out=0 with a done pulse.
REQ-028 Start op1 (3+4); in cycle 3 of op1 drive start=1 with a=8'h80, b=8'h80 -> the second request is ignored, result sum=8'h07, c_out=0, and a single done pulse.
REQ-029 start held high for 30 cycles with fixed operands -> done pulses every 10 cycles, busy low for exactly one cycle between operations, and sum stable between pulses.
REQ-030 After a completed 8'hFF+8'h01, start 8'h10+8'h20 and assert rst_n=0 mid-ADD -> busy, done, sum and c_out go to 0 asynchronously, and no done pulse follows.
REQ-031 Random regression of 1000 operand pairs, run at both WIDTH=8 and WIDTH=16 -> {c_out,sum} equals a+b and latency matches REQ-018 for every pair.
